// File: rtl/ec1_run_ctrl_if.sv
// Front-panel / CPU-side signal bundle for the EC1 run/debug sequencer.
// The master side is the panel plus the CPU control unit. The slave side is
// the sequencer, which drives the clock enable, the state and the counters.
interface ec1_run_ctrl_if #(
    parameter int PC_W  = 4,
    parameter int CNT_W = 16
);
    // Front-panel requests and breakpoint setup
    logic             run_btn;
    logic             step_btn;
    logic             stop_btn;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;

    // Observed CPU control-unit status
    logic [PC_W-1:0]  pc;
    logic             fetch;
    logic             halt_in;

    // Sequencer outputs
    logic             cpu_en;
    logic [2:0]       state_o;
    logic             bp_hit;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] instr_cnt;

    // Panel/CPU side: drives requests and status, observes the sequencer
    modport master (
        output run_btn,
        output step_btn,
        output stop_btn,
        output bp_en,
        output bp_addr,
        output pc,
        output fetch,
        output halt_in,
        input  cpu_en,
        input  state_o,
        input  bp_hit,
        input  cyc_cnt,
        input  instr_cnt
    );

    // Sequencer side
    modport slave (
        input  run_btn,
        input  step_btn,
        input  stop_btn,
        input  bp_en,
        input  bp_addr,
        input  pc,
        input  fetch,
        input  halt_in,
        output cpu_en,
        output state_o,
        output bp_hit,
        output cyc_cnt,
        output instr_cnt
    );
endinterface

// File: rtl/ec1_run_ctrl.sv
// EC1 run/debug sequencer.
// Gates the accumulator CPU through a clock enable and provides free-run,
// single-instruction step, PC breakpoint, stop-at-boundary and halt capture.
// An instruction boundary is a FETCH cycle. The clock enable is combinational
// so the CPU freezes in the very cycle a stop condition is seen, before that
// FETCH executes. Enabled cycles and retired instructions are counted.
module ec1_run_ctrl #(
    parameter int PC_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          Reset,
    ec1_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        BREAK  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t           state_reg;
    logic             launch_reg;
    logic             stop_pend_reg;
    logic             bp_hit_reg;
    logic             run_prev_reg;
    logic             step_prev_reg;
    logic             stop_prev_reg;
    logic [CNT_W-1:0] cyc_cnt_reg;
    logic [CNT_W-1:0] instr_cnt_reg;

    logic             run_edge;
    logic             step_edge;
    logic             stop_edge;
    logic             boundary;
    logic             bp_match;
    logic             cpu_gate;
    logic [PC_W-1:0]  pc_cur;
    logic [PC_W-1:0]  bp_cur;

    // Rising-edge detection on the panel buttons and boundary/breakpoint
    // qualification. launch masks the fetch at the resume PC, so the
    // instruction under the PC always issues once after run or step.
    always_comb begin
        run_edge  = bus.run_btn  & ~run_prev_reg;
        step_edge = bus.step_btn & ~step_prev_reg;
        stop_edge = bus.stop_btn & ~stop_prev_reg;
        pc_cur    = bus.pc;
        bp_cur    = bus.bp_addr;
        boundary  = bus.fetch & ~launch_reg;
        bp_match  = bus.bp_en & (pc_cur == bp_cur);
    end

    // Mealy clock enable: freezes the CPU in the same cycle as a halt, a
    // pending stop or a breakpoint hit at a boundary.
    always_comb begin
        cpu_gate = 1'b0;
        case (state_reg)
            RUN:     cpu_gate = ~bus.halt_in & ~(boundary & (stop_pend_reg | bp_match));
            STEP:    cpu_gate = ~bus.halt_in & ~boundary;
            default: cpu_gate = 1'b0;
        endcase
    end

    // Previous-value registers for button edge detection
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            run_prev_reg  <= 1'b0;
            step_prev_reg <= 1'b0;
            stop_prev_reg <= 1'b0;
        end else begin
            run_prev_reg  <= bus.run_btn;
            step_prev_reg <= bus.step_btn;
            stop_prev_reg <= bus.stop_btn;
        end
    end

    // Sequencer FSM with launch/stop-pending flags and registered bp_hit
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            launch_reg    <= 1'b0;
            stop_pend_reg <= 1'b0;
            bp_hit_reg    <= 1'b0;
        end else begin
            // The first enabled cycle after resume consumes the launch mask
            if (cpu_gate) begin
                launch_reg <= 1'b0;
            end

            case (state_reg)
                IDLE, BREAK: begin
                    // Stop edges are meaningless while frozen and are dropped
                    if (bus.halt_in) begin
                        state_reg  <= HALTED;
                        bp_hit_reg <= 1'b0;
                    end else if (run_edge) begin
                        state_reg  <= RUN;
                        launch_reg <= 1'b1;
                        bp_hit_reg <= 1'b0;
                    end else if (step_edge) begin
                        state_reg  <= STEP;
                        launch_reg <= 1'b1;
                        bp_hit_reg <= 1'b0;
                    end
                end

                RUN: begin
                    if (bus.halt_in) begin
                        state_reg <= HALTED;
                    end else if (boundary && stop_pend_reg) begin
                        state_reg     <= IDLE;
                        stop_pend_reg <= 1'b0;
                    end else begin
                        if (boundary && bp_match) begin
                            state_reg  <= BREAK;
                            bp_hit_reg <= 1'b1;
                        end
                        // A stop request only becomes effective at the next
                        // boundary, even if it arrives on a boundary itself.
                        if (stop_edge) begin
                            stop_pend_reg <= 1'b1;
                        end
                    end
                end

                STEP: begin
                    // Single instruction: stop at the next fetch, ignore
                    // the breakpoint and every button.
                    if (bus.halt_in) begin
                        state_reg <= HALTED;
                    end else if (boundary) begin
                        state_reg <= IDLE;
                    end
                end

                HALTED: begin
                    // Sticky until the asynchronous reset
                    state_reg <= HALTED;
                end

                default: begin
                    state_reg  <= IDLE;
                    bp_hit_reg <= 1'b0;
                end
            endcase
        end
    end

    // Enabled-cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cyc_cnt_reg   <= '0;
            instr_cnt_reg <= '0;
        end else if (cpu_gate) begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
            if (bus.fetch) begin
                instr_cnt_reg <= instr_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.cpu_en    = cpu_gate;
    assign bus.state_o   = state_reg;
    assign bus.bp_hit    = bp_hit_reg;
    assign bus.cyc_cnt   = cyc_cnt_reg;
    assign bus.instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_ec1_run_ctrl.sv
// Bench for the EC1 run/debug sequencer. A tiny CPU model executes
// 3-cycle instructions (FETCH, DECODE, EXEC) only on enabled cycles.
// Expected values are queued when a step is driven and popped on checking.
module tb_ec1_run_ctrl;

    localparam int PC_W  = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    ec1_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    ec1_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // CPU model state
    int              phase;
    logic [PC_W-1:0] mpc;

    // Scoreboard
    string       tagq[$];
    logic [31:0] valq[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic sb_push(input string tag, input logic [31:0] v);
        tagq.push_back(tag);
        valq.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        string       etag;
        logic [31:0] ev;
        checks++;
        if (tagq.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0d expected=<nothing queued>", tag, obs);
        end else begin
            etag = tagq.pop_front();
            ev   = valq.pop_front();
            assert (etag == tag && obs === ev) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d (queued as %s)", tag, obs, ev, etag);
            end
        end
    endtask

    task automatic drive_model();
        bus.fetch = (phase == 0);
        bus.pc    = mpc;
    endtask

    // One clock: entered and left at the falling edge
    task automatic cycle(output logic en, output logic f);
        #1;
        en = bus.cpu_en;
        f  = bus.fetch;
        @(posedge clk);
        #1;
        if (en === 1'b1) begin
            if (phase == 0) mpc = mpc + 1'b1;
            phase = (phase == 2) ? 0 : phase + 1;
        end
        drive_model();
        @(negedge clk);
    endtask

    task automatic press(input logic r, input logic s, input logic p, output logic en);
        logic f;
        bus.run_btn  = r;
        bus.step_btn = s;
        bus.stop_btn = p;
        cycle(en, f);
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        bus.stop_btn = 1'b0;
    endtask

    task automatic run_n(input int n, output int n_en);
        logic e, f;
        n_en = 0;
        for (int i = 0; i < n; i++) begin
            cycle(e, f);
            if (e === 1'b1) n_en++;
        end
    endtask

    task automatic run_until(input logic [2:0] target, input int budget, output int n_en,
                             output logic last_en, output logic last_f, output logic reached);
        logic e, f;
        n_en    = 0;
        reached = 1'b0;
        last_en = 1'bx;
        last_f  = 1'bx;
        for (int i = 0; i < budget && !reached; i++) begin
            cycle(e, f);
            if (e === 1'b1) n_en++;
            last_en = e;
            last_f  = f;
            if (bus.state_o === target) reached = 1'b1;
        end
    endtask

    // Reset pulse between clock edges; also restarts the CPU model at pc=0
    task automatic do_reset();
        Reset = 1'b0;
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        bus.stop_btn = 1'b0;
        bus.halt_in  = 1'b0;
        phase = 0;
        mpc   = '0;
        drive_model();
        #2;
        Reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic e, lf, rch;

        Reset        = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        bus.stop_btn = 1'b0;
        bus.halt_in  = 1'b0;
        phase = 0;
        mpc   = '0;
        drive_model();
        @(negedge clk);
        @(negedge clk);

        // ---- Reset state ----
        sb_push("rst_state", 0); sb_push("rst_cpu_en", 0); sb_push("rst_bp_hit", 0);
        sb_push("rst_cyc", 0);   sb_push("rst_instr", 0);
        do_reset();
        sb_check("rst_state", bus.state_o);
        sb_check("rst_cpu_en", bus.cpu_en);
        sb_check("rst_bp_hit", bus.bp_hit);
        sb_check("rst_cyc", bus.cyc_cnt);
        sb_check("rst_instr", bus.instr_cnt);

        // ---- Single step of a 3-cycle instruction ----
        sb_push("step_state", 2);
        press(1'b0, 1'b1, 1'b0, e);
        sb_check("step_state", bus.state_o);
        sb_push("step_done", 1); sb_push("step_en_cycles", 3); sb_push("step_stop_en", 0);
        sb_push("step_stop_fetch", 1); sb_push("step_end_state", 0);
        sb_push("step_instr", 1); sb_push("step_cyc", 3);
        run_until(3'd0, 12, n, lf, e, rch);
        sb_check("step_done", rch);
        sb_check("step_en_cycles", n);
        sb_check("step_stop_en", lf);
        sb_check("step_stop_fetch", e);
        sb_check("step_end_state", bus.state_o);
        sb_check("step_instr", bus.instr_cnt);
        sb_check("step_cyc", bus.cyc_cnt);

        // ---- Breakpoint at pc=4, then resume over it ----
        do_reset();
        bus.bp_en   = 1'b1;
        bus.bp_addr = 4'd4;
        sb_push("bp_run_state", 1);
        press(1'b1, 1'b0, 1'b0, e);
        sb_check("bp_run_state", bus.state_o);
        sb_push("bp_reached", 1); sb_push("bp_en_cycles", 12); sb_push("bp_stop_en", 0);
        sb_push("bp_hit", 1); sb_push("bp_instr", 4); sb_push("bp_cyc", 12);
        run_until(3'd3, 40, n, lf, e, rch);
        sb_check("bp_reached", rch);
        sb_check("bp_en_cycles", n);
        sb_check("bp_stop_en", lf);
        sb_check("bp_hit", bus.bp_hit);
        sb_check("bp_instr", bus.instr_cnt);
        sb_check("bp_cyc", bus.cyc_cnt);
        sb_push("bp_resume_state", 1); sb_push("bp_resume_hit", 0);
        press(1'b1, 1'b0, 1'b0, e);
        sb_check("bp_resume_state", bus.state_o);
        sb_check("bp_resume_hit", bus.bp_hit);
        sb_push("bp_resume_en", 3); sb_push("bp_resume_run", 1);
        sb_push("bp_resume_instr", 5); sb_push("bp_resume_cyc", 15);
        run_n(3, n);
        sb_check("bp_resume_en", n);
        sb_check("bp_resume_run", bus.state_o);
        sb_check("bp_resume_instr", bus.instr_cnt);
        sb_check("bp_resume_cyc", bus.cyc_cnt);
        bus.bp_en = 1'b0;

        // ---- Stop mid-instruction, resume, stop on a boundary ----
        do_reset();
        press(1'b1, 1'b0, 1'b0, e);
        sb_push("stop_pre_en", 4);
        run_n(4, n);
        sb_check("stop_pre_en", n);
        sb_push("stop_press_en", 1);
        press(1'b0, 1'b0, 1'b1, e);
        sb_check("stop_press_en", e);
        sb_push("stop_reached", 1); sb_push("stop_en_cycles", 1); sb_push("stop_cpu_en", 0);
        sb_push("stop_cyc", 6); sb_push("stop_instr", 2);
        run_until(3'd0, 10, n, lf, e, rch);
        sb_check("stop_reached", rch);
        sb_check("stop_en_cycles", n);
        sb_check("stop_cpu_en", lf);
        sb_check("stop_cyc", bus.cyc_cnt);
        sb_check("stop_instr", bus.instr_cnt);
        sb_push("stop_resume_state", 1);
        press(1'b1, 1'b0, 1'b0, e);
        sb_check("stop_resume_state", bus.state_o);
        sb_push("stop_resume_en", 4); sb_push("stop_resume_run", 1);
        run_n(4, n);
        sb_check("stop_resume_en", n);
        sb_check("stop_resume_run", bus.state_o);
        run_n(2, n);
        sb_push("stop_on_bnd_en", 1);
        press(1'b0, 1'b0, 1'b1, e);
        sb_check("stop_on_bnd_en", e);
        sb_push("stop_bnd_reached", 1); sb_push("stop_bnd_en_cycles", 2);
        sb_push("stop_bnd_instr", 5); sb_push("stop_bnd_cyc", 15);
        run_until(3'd0, 10, n, lf, e, rch);
        sb_check("stop_bnd_reached", rch);
        sb_check("stop_bnd_en_cycles", n);
        sb_check("stop_bnd_instr", bus.instr_cnt);
        sb_check("stop_bnd_cyc", bus.cyc_cnt);

        // ---- Halt capture ----
        do_reset();
        press(1'b1, 1'b0, 1'b0, e);
        run_n(2, n);
        bus.halt_in = 1'b1;
        sb_push("halt_same_cycle_en", 0); sb_push("halt_state", 4);
        cycle(e, lf);
        sb_check("halt_same_cycle_en", e);
        sb_check("halt_state", bus.state_o);
        bus.halt_in = 1'b0;
        sb_push("halt_run_state", 4); sb_push("halt_step_state", 4);
        sb_push("halt_stop_state", 4); sb_push("halt_frozen_en", 0);
        sb_push("halt_cyc", 2); sb_push("halt_instr", 1);
        press(1'b1, 1'b0, 1'b0, e);
        sb_check("halt_run_state", bus.state_o);
        press(1'b0, 1'b1, 1'b0, e);
        sb_check("halt_step_state", bus.state_o);
        press(1'b0, 1'b0, 1'b1, e);
        sb_check("halt_stop_state", bus.state_o);
        sb_check("halt_frozen_en", bus.cpu_en);
        sb_check("halt_cyc", bus.cyc_cnt);
        sb_check("halt_instr", bus.instr_cnt);
        sb_push("halt_rst_state", 0); sb_push("halt_rst_cyc", 0);
        do_reset();
        sb_check("halt_rst_state", bus.state_o);
        sb_check("halt_rst_cyc", bus.cyc_cnt);

        // ---- Simultaneous run+step, step ignored in RUN ----
        sb_push("sim_edges_state", 1);
        press(1'b1, 1'b1, 1'b0, e);
        sb_check("sim_edges_state", bus.state_o);
        run_n(2, n);
        sb_push("run_step_en", 1); sb_push("run_step_state", 1);
        press(1'b0, 1'b1, 1'b0, e);
        sb_check("run_step_en", e);
        sb_check("run_step_state", bus.state_o);
        sb_push("run_after_step_en", 3); sb_push("run_after_step_state", 1);
        run_n(3, n);
        sb_check("run_after_step_en", n);
        sb_check("run_after_step_state", bus.state_o);

        // ---- Counter wrap and asynchronous reset ----
        do_reset();
        press(1'b1, 1'b0, 1'b0, e);
        sb_push("wrap_en_cycles", 17); sb_push("wrap_cyc", 1); sb_push("wrap_instr", 6);
        run_n(17, n);
        sb_check("wrap_en_cycles", n);
        sb_check("wrap_cyc", bus.cyc_cnt);
        sb_check("wrap_instr", bus.instr_cnt);
        sb_push("async_state", 0); sb_push("async_cyc", 0); sb_push("async_instr", 0);
        sb_push("async_cpu_en", 0);
        #1;
        Reset = 1'b0;
        #1;
        sb_check("async_state", bus.state_o);
        sb_check("async_cyc", bus.cyc_cnt);
        sb_check("async_instr", bus.instr_cnt);
        sb_check("async_cpu_en", bus.cpu_en);
        Reset = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ec1_run_ctrl.md
Name: ec1_run_ctrl

Overview:
- Run/debug sequencer for the EC1 accumulator CPU.
- Gates the CPU with a clock enable. Supports free-run, single-instruction step, a PC breakpoint, stop-at-boundary and halt capture.
- Sits between the front-panel controls and the CPU's control unit. Reads the control unit's fetch indicator (IRload), its halt flag (H) and the PC.
- Counts enabled cycles and retired instructions for display.

Parameters:
- PC_W, 4, width of the program counter and the breakpoint address.
- CNT_W, 16, width of the cycle and instruction counters.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- run_btn  in  1  request free-run; rising edge acts.
- step_btn  in  1  request one instruction; rising edge acts.
- stop_btn  in  1  request stop at next instruction boundary; rising edge acts.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  CPU program counter.
- fetch  in  1  high while the CPU control unit is in FETCH (its IRload).
- halt_in  in  1  CPU H flag.
- cpu_en  out  1  CPU clock enable; the CPU advances only on cycles with cpu_en=1.
- state_o  out  3  encoded state: IDLE=0, RUN=1, STEP=2, BREAK=3, HALTED=4.
- bp_hit  out  1  high while in BREAK.
- cyc_cnt  out  CNT_W  count of cycles with cpu_en=1.
- instr_cnt  out  CNT_W  count of cycles with cpu_en=1 and fetch=1.

Behaviour:
- Inputs are already synchronous to clk; there is no synchronizer inside. Each button has a registered previous-value; edge = btn & ~prev.
- Reset (Reset=0), asynchronous:
  - state=IDLE, launch=0, stop_pend=0, all button prev-values=0.
  - cyc_cnt=0, instr_cnt=0, cpu_en=0, bp_hit=0.
- launch flag:
  - Set on the transition into RUN or STEP.
  - Cleared on the first cycle with cpu_en=1.
  - Purpose: the instruction at the current PC always issues once after resume, so a breakpoint or step boundary at the current PC cannot re-trigger.
- boundary = fetch & ~launch.
- cpu_en is combinational (Mealy) so the CPU freezes in the same cycle a stop condition is seen, before FETCH executes:
  - IDLE, BREAK, HALTED: cpu_en=0.
  - RUN: cpu_en = ~halt_in & ~(boundary & (stop_pend | (bp_en & pc==bp_addr))).
  - STEP: cpu_en = ~halt_in & ~boundary.
- Transitions, evaluated in priority order:
  1. Any state except HALTED with halt_in=1 goes to HALTED. HALTED is left only by Reset.
  2. IDLE or BREAK:
     - run edge goes to RUN; otherwise step edge goes to STEP.
     - Run wins when both edges arrive in the same cycle.
     - stop edge is ignored.
  3. RUN:
     - boundary & stop_pend goes to IDLE and clears stop_pend.
     - Otherwise boundary & bp_en & pc==bp_addr goes to BREAK.
     - A stop edge in RUN sets stop_pend.
     - A stop edge coincident with a boundary takes effect at the next boundary, not the current one.
     - Run and step edges in RUN are ignored.
  4. STEP: boundary goes to IDLE. The breakpoint is not checked in STEP. All button edges are ignored.
- Counters:
  - cyc_cnt += 1 on every cpu_en=1 cycle.
  - instr_cnt += 1 on every cpu_en=1 & fetch=1 cycle.
  - Both wrap modulo 2^CNT_W. Neither counts while frozen.
- bp_hit = (state==BREAK). state_o is the registered state.
- Reset mid-instruction returns to IDLE with counters cleared. The CPU's own reset is separate; this block does not drive it.

Test Plan:
1. Step: the CPU model runs a 3-cycle IN instruction (FETCH, DECODE, IN) from pc=0.
   - Step edge in IDLE gives STEP.
   - cpu_en=1 for exactly 3 cycles, then 0 on the next fetch, and state returns to IDLE.
   - instr_cnt=1, cyc_cnt=3.
2. Breakpoint: bp_en=1, bp_addr=4, run from pc=0.
   - cpu_en drops in the cycle fetch=1 & pc=4, state=BREAK, bp_hit=1, instr_cnt=4.
   - A following run edge fetches pc=4 once without re-trigger; instr_cnt becomes 5.
3. Stop: stop edge mid-instruction in RUN.
   - Execution continues to the next fetch, then cpu_en=0 and state=IDLE.
   - stop_pend is cleared; a second run edge resumes.
4. Halt: the CPU model raises halt_in during RUN.
   - cpu_en=0 that same cycle, state=HALTED next cycle.
   - Subsequent run, step and stop edges leave it HALTED; only Reset=0 returns IDLE with counters 0.
5. Simultaneous edges: run and step edges in the same cycle from IDLE give RUN. A step edge during RUN is ignored and state stays RUN.
6. Counter wrap and async reset:
   - With CNT_W=4, 17 enabled cycles give cyc_cnt=1.
   - Asserting Reset=0 between clock edges clears state and counters immediately, without waiting for a clock edge.
